// File: rtl/apb4_crc_gen_if.sv
// ----------------------------------------------------------------------------
// apb4_crc_gen_if
//   APB4 bus bundle for the CRC generator slave.
//   master modport : drives paddr/psel/penable/pwrite/pwdata, samples responses
//   slave  modport : samples the request, drives prdata/pready/pslverr
// ----------------------------------------------------------------------------
interface apb4_crc_gen_if;
    logic [5:0]  paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (
        output paddr, psel, penable, pwrite, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb4_crc_gen.sv
// ----------------------------------------------------------------------------
// apb4_crc_gen
//   APB4 slave computing a CRC of CRC_WIDTH bits with programmable polynomial,
//   init value, xor-out value and input/output bit reflection. Data words are
//   queued in a FIFO and folded BITS_PER_CYC bits per clock, MSB first.
// Ports
//   pclk  : single clock
//   prst  : synchronous active-high reset
//   apb   : APB4 slave bundle (zero wait state, pready tied high)
//   irq_o : CTRL.ie & STAT.done
// Register map (index = paddr[5:2])
//   0 CTRL, 1 POLY, 2 INIT, 3 XORV, 4 DATA (wo), 5 RSLT (ro), 6 STAT
// ----------------------------------------------------------------------------
module apb4_crc_gen #(
    parameter int CRC_WIDTH    = 32,
    parameter int BITS_PER_CYC = 8,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic          pclk,
    input  logic          prst,
    apb4_crc_gen_if.slave apb,
    output logic          irq_o
);
    localparam int W     = CRC_WIDTH;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [3:0] IDX_CTRL = 4'd0;
    localparam logic [3:0] IDX_POLY = 4'd1;
    localparam logic [3:0] IDX_INIT = 4'd2;
    localparam logic [3:0] IDX_XORV = 4'd3;
    localparam logic [3:0] IDX_DATA = 4'd4;
    localparam logic [3:0] IDX_RSLT = 4'd5;
    localparam logic [3:0] IDX_STAT = 4'd6;

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_t;

    function automatic logic [31:0] rev32(input logic [31:0] d);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = d[31-i];
        return r;
    endfunction

    function automatic logic [W-1:0] rev_w(input logic [W-1:0] d);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = d[W-1-i];
        return r;
    endfunction

    // Folds BITS_PER_CYC data bits (din MSB first) into the CRC register.
    function automatic logic [W-1:0] crc_fold(input logic [W-1:0] crc,
                                              input logic [W-1:0] poly,
                                              input logic [BITS_PER_CYC-1:0] din);
        logic [W-1:0] c;
        logic         fb;
        c = crc;
        for (int i = BITS_PER_CYC - 1; i >= 0; i--) begin
            fb = c[W-1] ^ din[i];
            c  = {c[W-2:0], 1'b0} ^ (fb ? poly : {W{1'b0}});
        end
        return c;
    endfunction

    logic             r_en, r_revin, r_revout, r_ie;
    logic [1:0]       r_size;
    logic [W-1:0]     r_poly, r_init, r_xorv, r_crc;
    logic             r_ovf, r_done;
    logic [31:0]      r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wptr, r_rptr;
    logic [CNT_W-1:0] r_count;
    state_t           r_state, w_state_nxt;
    logic [31:0]      r_shift;
    logic [5:0]       r_cyc;

    logic        w_access, w_wr, w_rd, w_full, w_empty, w_busy;
    logic [3:0]  w_idx;
    logic        w_data_wr, w_push, w_ovf_set, w_cfg_wr, w_cfg_err, w_cfg_ok;
    logic        w_ctrl_wr, w_clr, w_stat_wr, w_bad_idx, w_pop, w_last;
    logic [5:0]  w_size_bits, w_cyc_init;
    logic [31:0] w_head, w_aligned, w_prdata;
    logic [W-1:0] w_rslt;
    logic [3:0]  w_count4;
    logic        w_unused_addr;

    assign w_access  = apb.psel && apb.penable;
    assign w_wr      = w_access && apb.pwrite;
    assign w_rd      = w_access && !apb.pwrite;
    assign w_idx     = apb.paddr[5:2];
    assign w_unused_addr = ^apb.paddr[1:0];

    assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_empty   = (r_count == {CNT_W{1'b0}});
    assign w_busy    = !w_empty || (r_state == ST_SHIFT);

    // A full FIFO rejects the push even if the engine pops in the same cycle.
    assign w_data_wr = w_wr && (w_idx == IDX_DATA);
    assign w_push    = w_data_wr && !w_full;
    assign w_ovf_set = w_data_wr && w_full;
    assign w_cfg_wr  = w_wr && ((w_idx == IDX_POLY) || (w_idx == IDX_INIT) || (w_idx == IDX_XORV));
    assign w_cfg_err = w_cfg_wr && w_busy;
    assign w_cfg_ok  = w_cfg_wr && !w_busy;
    assign w_ctrl_wr = w_wr && (w_idx == IDX_CTRL);
    assign w_clr     = w_ctrl_wr && apb.pwdata[1];
    assign w_stat_wr = w_wr && (w_idx == IDX_STAT);
    assign w_bad_idx = (w_idx > IDX_STAT);

    assign w_head     = r_fifo[r_rptr];
    assign w_cyc_init = (w_size_bits / 6'(BITS_PER_CYC)) - 6'd1;
    // Full reversal also left-aligns the low SIZE bits, LSB first.
    assign w_aligned  = r_revin ? rev32(w_head) : (w_head << (6'd32 - w_size_bits));

    assign w_rslt   = (r_revout ? rev_w(r_crc) : r_crc) ^ r_xorv;
    assign w_count4 = 4'(r_count);

    assign apb.prdata  = w_prdata;
    assign apb.pready  = 1'b1;
    assign apb.pslverr = w_access && (w_bad_idx || w_ovf_set || w_cfg_err);
    assign irq_o       = r_ie && r_done;

    // Word size decode from CTRL.size.
    always_comb begin
        w_size_bits = 6'd32;
        case (r_size)
            2'd0:    w_size_bits = 6'd8;
            2'd1:    w_size_bits = 6'd16;
            default: w_size_bits = 6'd32;
        endcase
    end

    // Engine next-state logic; clr forces IDLE and suppresses pop/fold.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_last      = 1'b0;
        if (w_clr) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_en && !w_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = ST_SHIFT;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    if (r_cyc == 6'd0) begin
                        w_last      = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_SHIFT;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Engine state register.
    always_ff @(posedge pclk) begin
        if (prst) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    // CRC datapath: load on pop, fold during SHIFT, reload INIT on clr.
    always_ff @(posedge pclk) begin
        if (prst) begin
            r_crc   <= {W{1'b0}};
            r_shift <= 32'd0;
            r_cyc   <= 6'd0;
        end else if (w_clr) begin
            r_crc   <= r_init;
            r_shift <= 32'd0;
            r_cyc   <= 6'd0;
        end else if (w_pop) begin
            r_shift <= w_aligned;
            r_cyc   <= w_cyc_init;
        end else if (r_state == ST_SHIFT) begin
            r_crc   <= crc_fold(r_crc, r_poly, r_shift[31 -: BITS_PER_CYC]);
            r_shift <= r_shift << BITS_PER_CYC;
            r_cyc   <= r_cyc - 6'd1;
        end
    end

    // Configuration registers.
    always_ff @(posedge pclk) begin
        if (prst) begin
            r_en     <= 1'b0;
            r_revin  <= 1'b0;
            r_revout <= 1'b0;
            r_size   <= 2'd0;
            r_ie     <= 1'b0;
            r_poly   <= {W{1'b0}};
            r_init   <= {W{1'b0}};
            r_xorv   <= {W{1'b0}};
        end else begin
            if (w_ctrl_wr) begin
                r_en     <= apb.pwdata[0];
                r_revin  <= apb.pwdata[2];
                r_revout <= apb.pwdata[3];
                r_size   <= apb.pwdata[5:4];
                r_ie     <= apb.pwdata[6];
            end
            if (w_cfg_ok) begin
                case (w_idx)
                    IDX_POLY: r_poly <= apb.pwdata[W-1:0];
                    IDX_INIT: r_init <= apb.pwdata[W-1:0];
                    IDX_XORV: r_xorv <= apb.pwdata[W-1:0];
                    default:  r_poly <= r_poly;
                endcase
            end
        end
    end

    // Sticky status flags; hardware set wins over a same-cycle W1C.
    always_ff @(posedge pclk) begin
        if (prst) begin
            r_ovf  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            if (w_ovf_set)                        r_ovf <= 1'b1;
            else if (w_stat_wr && apb.pwdata[3])  r_ovf <= 1'b0;

            if (w_clr)                            r_done <= 1'b0;
            else if (w_last && w_empty)           r_done <= 1'b1;
            else if (w_stat_wr && apb.pwdata[4])  r_done <= 1'b0;
        end
    end

    // FIFO pointers and occupancy; clr flushes.
    always_ff @(posedge pclk) begin
        if (prst || w_clr) begin
            r_wptr  <= {PTR_W{1'b0}};
            r_rptr  <= {PTR_W{1'b0}};
            r_count <= {CNT_W{1'b0}};
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage; contents are meaningless while count is zero.
    always_ff @(posedge pclk) begin
        if (w_push) r_fifo[r_wptr] <= apb.pwdata;
    end

    // Read mux; zero outside a read access.
    always_comb begin
        w_prdata = 32'd0;
        if (w_rd) begin
            case (w_idx)
                IDX_CTRL: w_prdata = {25'd0, r_ie, r_size, r_revout, r_revin, 1'b0, r_en};
                IDX_POLY: w_prdata = 32'(r_poly);
                IDX_INIT: w_prdata = 32'(r_init);
                IDX_XORV: w_prdata = 32'(r_xorv);
                IDX_RSLT: w_prdata = 32'(w_rslt);
                IDX_STAT: w_prdata = {20'd0, w_count4, 3'd0, r_done, r_ovf, w_empty, w_full, w_busy};
                default:  w_prdata = 32'd0;
            endcase
        end else begin
            w_prdata = 32'd0;
        end
    end
endmodule

// File: tb/tb_apb4_crc_gen.sv
// ----------------------------------------------------------------------------
// tb_apb4_crc_gen
//   Self-checking bench for apb4_crc_gen: a 32-bit instance and a 16-bit
//   instance share one APB driver; tgt selects which one is addressed.
// ----------------------------------------------------------------------------
module tb_apb4_crc_gen;
    localparam logic [5:0] A_CTRL = 6'h00, A_POLY = 6'h04, A_INIT = 6'h08, A_XORV = 6'h0C;
    localparam logic [5:0] A_DATA = 6'h10, A_RSLT = 6'h14, A_STAT = 6'h18;

    logic        pclk = 1'b0;
    logic        prst;
    logic [5:0]  paddr;
    logic        psel, penable, pwrite;
    logic [31:0] pwdata;
    int          tgt;
    logic        irq32, irq16;

    int total = 0;
    int bad   = 0;

    always #5 pclk = ~pclk;

    apb4_crc_gen_if u_if32 ();
    apb4_crc_gen_if u_if16 ();

    assign u_if32.paddr   = paddr;
    assign u_if32.psel    = psel && (tgt == 0);
    assign u_if32.penable = penable;
    assign u_if32.pwrite  = pwrite;
    assign u_if32.pwdata  = pwdata;
    assign u_if16.paddr   = paddr;
    assign u_if16.psel    = psel && (tgt == 1);
    assign u_if16.penable = penable;
    assign u_if16.pwrite  = pwrite;
    assign u_if16.pwdata  = pwdata;

    apb4_crc_gen #(.CRC_WIDTH(32), .BITS_PER_CYC(8), .FIFO_DEPTH(4)) u_dut32 (
        .pclk(pclk), .prst(prst), .apb(u_if32.slave), .irq_o(irq32));
    apb4_crc_gen #(.CRC_WIDTH(16), .BITS_PER_CYC(8), .FIFO_DEPTH(4)) u_dut16 (
        .pclk(pclk), .prst(prst), .apb(u_if16.slave), .irq_o(irq16));

    typedef struct {
        string       name;
        logic [31:0] exp;
        logic [31:0] mask;
        logic        exp_err;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic        wr;
        logic [5:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        logic        exp_err;
        string       name;
    } vec_t;
    vec_t vt[17];

    function automatic vec_t mk(input logic wr, input logic [5:0] a, input logic [31:0] wd,
                                input logic [31:0] exp, input logic err, input string name);
        vec_t v;
        v.wr = wr; v.addr = a; v.wdata = wd; v.exp = exp; v.exp_err = err; v.name = name;
        return v;
    endfunction

    // Bit-serial CRC of a 32-bit word, MSB first, no reflection.
    function automatic logic [31:0] model_msb(input logic [31:0] init, input logic [31:0] poly,
                                              input logic [31:0] data);
        logic [31:0] c;
        logic        fb;
        c = init;
        for (int b = 31; b >= 0; b--) begin
            fb = c[31] ^ data[b];
            c  = {c[30:0], 1'b0} ^ (fb ? poly : 32'd0);
        end
        return c;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic xfer(input logic wr, input logic [5:0] a, input logic [31:0] d,
                        input bit chk, output logic [31:0] rd);
        logic err;
        sb_t  e;
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(negedge pclk);
        rd  = (tgt == 0) ? u_if32.prdata  : u_if16.prdata;
        err = (tgt == 0) ? u_if32.pslverr : u_if16.pslverr;
        if (chk) begin
            if (sb_q.size() == 0) begin
                total++; bad++;
                $display("FAIL scoreboard_underflow got=%h exp=entry", rd);
            end else begin
                e = sb_q.pop_front();
                check({e.name, "_data"}, rd & e.mask, e.exp & e.mask);
                check({e.name, "_err"}, {31'd0, err}, {31'd0, e.exp_err});
            end
        end
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic chk_rd(input logic [5:0] a, input logic [31:0] exp, input logic [31:0] mask,
                          input string name);
        sb_t e;
        logic [31:0] rd;
        e.name = name; e.exp = exp; e.mask = mask; e.exp_err = 1'b0;
        sb_q.push_back(e);
        xfer(1'b0, a, 32'd0, 1'b1, rd);
    endtask

    task automatic chk_acc(input logic wr, input logic [5:0] a, input logic [31:0] d,
                           input logic [31:0] exp, input logic exp_err, input string name);
        sb_t e;
        logic [31:0] rd;
        e.name = name; e.exp = exp; e.mask = 32'hFFFF_FFFF; e.exp_err = exp_err;
        sb_q.push_back(e);
        xfer(wr, a, d, 1'b1, rd);
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        logic [31:0] rd;
        xfer(1'b1, a, d, 1'b0, rd);
    endtask

    task automatic wait_idle(input string name);
        logic [31:0] s;
        s = 32'd1;
        for (int n = 0; n < 64; n++) begin
            xfer(1'b0, A_STAT, 32'd0, 1'b0, s);
            if (!s[0]) break;
        end
        check({name, "_idle"}, {31'd0, s[0]}, 32'd0);
    endtask

    task automatic check_irq(input string name, input logic exp);
        @(negedge pclk);
        check(name, {31'd0, irq32}, {31'd0, exp});
    endtask

    task automatic run_vec(input int i);
        chk_acc(vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].exp, vt[i].exp_err, vt[i].name);
    endtask

    logic [31:0] exp_c;
    int          busy_cnt;

    initial begin
        tgt = 0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 6'd0; pwdata = 32'd0;
        prst = 1'b1;
        repeat (3) @(posedge pclk);
        #1 prst = 1'b0;

        vt[0]  = mk(1'b0, A_CTRL, 32'h0, 32'h0, 1'b0, "rst_ctrl");
        vt[1]  = mk(1'b0, A_POLY, 32'h0, 32'h0, 1'b0, "rst_poly");
        vt[2]  = mk(1'b0, A_INIT, 32'h0, 32'h0, 1'b0, "rst_init");
        vt[3]  = mk(1'b0, A_XORV, 32'h0, 32'h0, 1'b0, "rst_xorv");
        vt[4]  = mk(1'b0, A_RSLT, 32'h0, 32'h0, 1'b0, "rst_rslt");
        vt[5]  = mk(1'b0, A_STAT, 32'h0, 32'h4, 1'b0, "rst_stat");
        vt[6]  = mk(1'b0, A_DATA, 32'h0, 32'h0, 1'b0, "data_rd");
        vt[7]  = mk(1'b0, 6'h1C,  32'h0, 32'h0, 1'b1, "bad_rd");
        vt[8]  = mk(1'b1, 6'h3C,  32'hFFFF_FFFF, 32'h0, 1'b1, "bad_wr");
        vt[9]  = mk(1'b1, A_POLY, 32'hA5A5_A5A5, 32'h0, 1'b0, "poly_wr");
        vt[10] = mk(1'b0, A_POLY, 32'h0, 32'hA5A5_A5A5, 1'b0, "poly_rd");
        vt[11] = mk(1'b1, A_CTRL, 32'h7F, 32'h0, 1'b0, "ctrl_wr");
        vt[12] = mk(1'b0, A_CTRL, 32'h0, 32'h7D, 1'b0, "ctrl_rd");
        vt[13] = mk(1'b1, A_CTRL, 32'h0, 32'h0, 1'b0, "ctrl_wr0");
        vt[14] = mk(1'b1, A_XORV, 32'h1234_5678, 32'h0, 1'b0, "xorv_wr");
        vt[15] = mk(1'b0, A_RSLT, 32'h0, 32'h1234_5678, 1'b0, "rslt_xorv");
        vt[16] = mk(1'b0, A_STAT, 32'h0, 32'h4, 1'b0, "stat_idle");

        check_irq("rst_irq", 1'b0);
        for (int i = 0; i < 17; i++) run_vec(i);

        // CRC-32 check value with reflection
        wr(A_POLY, 32'h04C1_1DB7);
        wr(A_INIT, 32'hFFFF_FFFF);
        wr(A_XORV, 32'hFFFF_FFFF);
        wr(A_CTRL, 32'h0F);
        for (int i = 0; i < 9; i++) wr(A_DATA, 32'h31 + 32'(i));
        wait_idle("crc32");
        chk_rd(A_RSLT, 32'hCBF4_3926, 32'hFFFF_FFFF, "crc32_rslt");
        chk_rd(A_STAT, 32'h10, 32'h10, "crc32_done");
        check_irq("crc32_irq_ie0", 1'b0);
        wr(A_CTRL, 32'h4D);
        check_irq("crc32_irq_ie1", 1'b1);
        wr(A_STAT, 32'h10);
        check_irq("crc32_irq_w1c", 1'b0);
        chk_rd(A_STAT, 32'h0, 32'h18, "crc32_w1c");

        // CRC-16/CCITT-FALSE on the 16-bit instance
        tgt = 1;
        wr(A_POLY, 32'hFFFF_1021);
        chk_rd(A_POLY, 32'h0000_1021, 32'hFFFF_FFFF, "crc16_poly");
        wr(A_INIT, 32'h0000_FFFF);
        wr(A_XORV, 32'h0);
        wr(A_CTRL, 32'h03);
        for (int i = 0; i < 9; i++) wr(A_DATA, 32'h31 + 32'(i));
        wait_idle("crc16");
        chk_rd(A_RSLT, 32'h0000_29B1, 32'hFFFF_FFFF, "crc16_rslt");
        check("crc16_irq", {31'd0, irq16}, 32'd0);
        tgt = 0;

        // 32-bit word versus four bytes
        exp_c = model_msb(32'hFFFF_FFFF, 32'h04C1_1DB7, 32'h3132_3334);
        wr(A_XORV, 32'h0);
        wr(A_CTRL, 32'h23);
        wr(A_DATA, 32'h3132_3334);
        busy_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge pclk);
            if (u_dut32.w_busy) busy_cnt++;
        end
        check("size32_busy_cycles", 32'(busy_cnt), 32'd5);
        chk_rd(A_RSLT, exp_c, 32'hFFFF_FFFF, "size32_rslt");
        wr(A_CTRL, 32'h03);
        for (int i = 0; i < 4; i++) wr(A_DATA, 32'h31 + 32'(i));
        wait_idle("size8x4");
        chk_rd(A_RSLT, exp_c, 32'hFFFF_FFFF, "size8x4_rslt");

        // Overflow with the engine disabled, then config write while busy
        wr(A_CTRL, 32'h02);
        for (int i = 0; i < 4; i++) chk_acc(1'b1, A_DATA, 32'h100 + 32'(i), 32'h0, 1'b0, "ovf_push");
        chk_acc(1'b1, A_DATA, 32'h1FF, 32'h0, 1'b1, "ovf_push_full");
        chk_rd(A_STAT, 32'h0000_040B, 32'hFFFF_FFFF, "ovf_stat");
        wr(A_STAT, 32'h08);
        chk_rd(A_STAT, 32'h0000_0403, 32'hFFFF_FFFF, "ovf_w1c");
        chk_acc(1'b1, A_POLY, 32'h1111_1111, 32'h0, 1'b1, "poly_busy_wr");
        chk_rd(A_POLY, 32'h04C1_1DB7, 32'hFFFF_FFFF, "poly_busy_keep");

        // clr in the middle of a 32-bit word
        wr(A_CTRL, 32'h22);
        chk_acc(1'b1, A_XORV, 32'h0F0F_0F0F, 32'h0, 1'b0, "clr_xorv_wr");
        wr(A_DATA, 32'hAAAA_5555);
        wr(A_DATA, 32'h5555_AAAA);
        wr(A_CTRL, 32'h21);
        wr(A_CTRL, 32'h22);
        chk_rd(A_STAT, 32'h0000_0004, 32'hFFFF_FFFF, "clr_stat");
        chk_rd(A_RSLT, 32'hF0F0_F0F0, 32'hFFFF_FFFF, "clr_rslt");

        // Reset in the middle of SHIFT
        wr(A_CTRL, 32'h63);
        wr(A_DATA, 32'hDEAD_BEEF);
        wait_idle("pre_rst");
        check_irq("pre_rst_irq", 1'b1);
        wr(A_DATA, 32'h1234_5678);
        @(posedge pclk); #1 prst = 1'b1;
        @(posedge pclk); #1 prst = 1'b0;
        check_irq("post_rst_irq", 1'b0);
        for (int i = 0; i < 6; i++) run_vec(i);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
